mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 60 ++++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every handshake and memory-bus signal around
// the fetch/memory-stage arbiter.
//
// Signal groups:
//   f_*   fetch requester: f_req, f_addr in; f_ready, f_data[79:0],
//         f_err, f_wait out of the arbiter.
//   m_*   memory-stage requester: m_req, m_we, m_addr, m_wdata in;
//         m_ready, m_rdata[63:0], m_err, m_wait out of the arbiter.
//   mem_* unified memory: mem_en, mem_we, mem_addr, mem_wdata out of the
//         arbiter; mem_ack, mem_rdata[79:0], mem_err into it.
//
// Modports:
//   slave  - the arbiter's view.
//   master - the view of the surrounding pipeline and memory (or a bench).
interface mem_arbiter_if #(
  parameter int ADDR_W = 64
);
  // Fetch stage
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ready;
  logic [79:0]       f_data;
  logic              f_err;
  logic              f_wait;

  // Memory stage
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [63:0]       m_wdata;
  logic              m_ready;
  logic [63:0]       m_rdata;
  logic              m_err;
  logic              m_wait;

  // Unified memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_ack;
  logic [79:0]       mem_rdata;
  logic              mem_err;

  modport slave (
    input  f_req, f_addr, m_req, m_we, m_addr, m_wdata,
           mem_ack, mem_rdata, mem_err,
    output f_ready, f_data, f_err, f_wait,
           m_ready, m_rdata, m_err, m_wait,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, m_req, m_we, m_addr, m_wdata,
           mem_ack, mem_rdata, mem_err,
    input  f_ready, f_data, f_err, f_wait,
           m_ready, m_rdata, m_err, m_wait,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one unified memory port between the fetch stage
// (10-byte instruction reads) and the memory stage (8-byte reads/writes).
// At most one transaction is outstanding. The memory stage normally wins,
// but after STARVE_MAX consecutive memory-stage grants while fetch is
// waiting, fetch is granted. A transaction that sees no mem_ack within
// TIMEOUT cycles is completed with an error.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    mem_arbiter_if.slave: fetch, memory-stage and unified-memory
//          signals (see mem_arbiter_if.sv)
//
// Parameters:
//   ADDR_W     byte-address width
//   TIMEOUT    cycles from issue to forced completion (2..255)
//   STARVE_MAX consecutive memory-stage grants tolerated while fetch waits
//              (1..15)
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_M = 2'd2
  } state_e;

  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;

  logic busy;
  logic timed_out;
  logic done;
  logic f_done;
  logic m_done;
  logic grant_m;
  logic grant_f;

  // Completion is combinational so that an ack in the first busy cycle
  // produces the ready pulse in that same cycle.
  always_comb begin
    busy      = (state_q != IDLE);
    timed_out = busy && (tcnt_q == TCNT_LAST);
    // A real ack takes precedence over a coincident timeout: the error and
    // data then come from the memory.
    done      = busy && (bus.mem_ack || timed_out);
    f_done    = done && (state_q == BUSY_F);
    m_done    = done && (state_q == BUSY_M);
  end

  // Grant decision, only meaningful in IDLE.
  always_comb begin
    grant_m = bus.m_req && (!bus.f_req || (starve_q < STARVE_LIM));
    grant_f = bus.f_req && !grant_m;
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    starve_d    = starve_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_m) begin
          state_d     = BUSY_M;
          tcnt_d      = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.m_we;
          mem_addr_d  = bus.m_addr;
          mem_wdata_d = bus.m_wdata;
          // With fetch waiting, grant_m implies starve_q < STARVE_MAX, so
          // the increment can never pass the limit.
          starve_d    = bus.f_req ? (starve_q + 4'd1) : 4'd0;
        end else if (grant_f) begin
          state_d     = BUSY_F;
          tcnt_d      = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.f_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      BUSY_F, BUSY_M: begin
        if (done) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Data and error are forced to zero outside the ready pulse; a forced
  // (timeout) completion carries zero data and err = 1.
  assign bus.f_ready = f_done;
  assign bus.f_err   = f_done && (bus.mem_ack ? bus.mem_err : 1'b1);
  assign bus.f_data  = (f_done && bus.mem_ack) ? bus.mem_rdata : 80'd0;
  assign bus.f_wait  = bus.f_req && !f_done;

  assign bus.m_ready = m_done;
  assign bus.m_err   = m_done && (bus.mem_ack ? bus.mem_err : 1'b1);
  assign bus.m_rdata = (m_done && bus.mem_ack) ? bus.mem_rdata[63:0] : 64'd0;
  assign bus.m_wait  = bus.m_req && !m_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter: directed scenarios
// for fetch reads, priority, starvation, timeout, ack/timeout collision and
// reset while busy, followed by randomized traffic scored against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int ADDR_W     = 64;
  localparam int TIMEOUT    = 16;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.f_req     = 1'b0;
    bus.f_addr    = '0;
    bus.m_req     = 1'b0;
    bus.m_we      = 1'b0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_err   = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Outputs forced to zero by reset.
  task automatic test_reset();
    logic [6:0] obs;
    do_reset();
    tick();
    bus.m_req   = 1'b1;
    bus.m_addr  = 64'h40;
    tick();
    rst_n       = 1'b0;
    bus.m_req   = 1'b0;
    bus.f_req   = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 80'h1234_5678_9ABC_DEF0_1122;
    #1;
    obs = {bus.f_ready, bus.m_ready, bus.f_err, bus.m_err, bus.mem_en, bus.mem_we, bus.f_wait};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=%b", obs, 7'b0000001);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.f_data, bus.m_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_buses got addr=%h wdata=%h fdata=%h mrdata=%h exp=0",
               bus.mem_addr, bus.mem_wdata, bus.f_data, bus.m_rdata);
    end
    $display("reset: outputs held at zero");
  endtask

  task automatic test_fetch_read();
    logic [79:0] rd;
    do_reset();
    rd = 80'h30F2_0A00_1122_3344_5566;
    bus.f_req  = 1'b1;
    bus.f_addr = 64'h100;
    #1;
    checks++;
    if ({bus.mem_en, bus.f_wait} !== 2'b01) begin
      errors++;
      $display("FAIL fetch_idle {mem_en,f_wait} got=%b exp=01", {bus.mem_en, bus.f_wait});
    end
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 64'h100}) begin
      errors++;
      $display("FAIL fetch_issue en=%b we=%b addr=%h exp en=1 we=0 addr=100",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    #1;
    checks++;
    if ({bus.f_ready, bus.f_err, bus.m_ready, bus.f_wait, bus.f_data} !== {4'b1000, rd}) begin
      errors++;
      $display("FAIL fetch_done rdy=%b err=%b mrdy=%b wait=%b data=%h exp 1,0,0,0 data=%h",
               bus.f_ready, bus.f_err, bus.m_ready, bus.f_wait, bus.f_data, rd);
    end
    tick();
    bus.f_req   = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if ({bus.f_ready, bus.f_wait, bus.mem_en, bus.f_data} !== '0) begin
      errors++;
      $display("FAIL fetch_after rdy=%b wait=%b en=%b data=%h exp all 0",
               bus.f_ready, bus.f_wait, bus.mem_en, bus.f_data);
    end
    $display("txn fetch addr=100 data=%h", rd);
  endtask

  task automatic test_priority();
    logic [79:0] rd;
    do_reset();
    rd = {16'($urandom), $urandom, $urandom};
    bus.f_req   = 1'b1;
    bus.f_addr  = 64'h300;
    bus.m_req   = 1'b1;
    bus.m_we    = 1'b1;
    bus.m_addr  = 64'h200;
    bus.m_wdata = 64'hDEAD;
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 64'h200, 64'hDEAD}) begin
      errors++;
      $display("FAIL prio_m_first en=%b we=%b addr=%h wdata=%h exp 1,1,200,dead",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    #1;
    checks++;
    if ({bus.m_ready, bus.f_ready, bus.m_err, bus.m_rdata} !== {3'b100, rd[63:0]}) begin
      errors++;
      $display("FAIL prio_m_done mrdy=%b frdy=%b err=%b rdata=%h exp 1,0,0 %h",
               bus.m_ready, bus.f_ready, bus.m_err, bus.m_rdata, rd[63:0]);
    end
    $display("txn prio M write addr=200 wdata=dead");
    tick();
    bus.m_req   = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 64'h300}) begin
      errors++;
      $display("FAIL prio_f_second en=%b we=%b addr=%h exp 1,0,300",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    #1;
    checks++;
    if ({bus.f_ready, bus.m_ready, bus.f_data} !== {2'b10, rd}) begin
      errors++;
      $display("FAIL prio_f_done frdy=%b mrdy=%b data=%h exp 1,0,%h",
               bus.f_ready, bus.m_ready, bus.f_data, rd);
    end
    $display("txn prio F read addr=300");
    tick();
    drive_idle();
  endtask

  // Fetch held while five memory-stage requests arrive back to back.
  task automatic test_starvation();
    int          exp_f[6];
    int          m_served;
    int          f_served;
    logic [63:0] exp_addr;
    exp_f    = '{0, 0, 0, 0, 1, 0};
    m_served = 0;
    f_served = 0;
    do_reset();
    for (int g = 0; g < 6; g++) begin
      bus.mem_ack = 1'b0;
      bus.m_req   = (m_served < 5);
      bus.m_we    = 1'b0;
      bus.m_addr  = 64'h1000 + 64'(m_served);
      bus.f_req   = (f_served == 0);
      bus.f_addr  = 64'hF00;
      exp_addr    = (exp_f[g] != 0) ? 64'hF00 : 64'h1000 + 64'(m_served);
      tick();
      checks++;
      if ({bus.mem_en, bus.mem_addr} !== {1'b1, exp_addr}) begin
        errors++;
        $display("FAIL starve_grant%0d en=%b addr=%h exp en=1 addr=%h",
                 g, bus.mem_en, bus.mem_addr, exp_addr);
      end
      bus.mem_ack = 1'b1;
      #1;
      checks++;
      if ({bus.f_ready, bus.m_ready} !== ((exp_f[g] != 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL starve_ready%0d {f,m}=%b exp=%b", g, {bus.f_ready, bus.m_ready},
                 (exp_f[g] != 0) ? 2'b10 : 2'b01);
      end
      $display("txn starve grant%0d %s addr=%h", g, (exp_f[g] != 0) ? "F" : "M", exp_addr);
      if (exp_f[g] != 0) f_served++;
      else m_served++;
      tick();
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    bus.m_req     = 1'b1;
    bus.m_addr    = 64'h800;
    bus.mem_rdata = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    tick();
    cyc = 1;
    while (!bus.m_ready && cyc < 40) begin
      checks++;
      if (bus.mem_en !== 1'b1) begin
        errors++;
        $display("FAIL timeout_en cyc=%0d got=%b exp=1", cyc, bus.mem_en);
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency got=%0d cycles exp=%0d", cyc, TIMEOUT);
    end
    checks++;
    if ({bus.m_ready, bus.m_err, bus.m_rdata} !== {2'b11, 64'd0}) begin
      errors++;
      $display("FAIL timeout_done rdy=%b err=%b rdata=%h exp 1,1,0",
               bus.m_ready, bus.m_err, bus.m_rdata);
    end
    $display("txn timeout M addr=800 after %0d cycles", cyc);
    tick();
    bus.m_req = 1'b0;
    #1;
    checks++;
    if ({bus.mem_en, bus.m_ready} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_after en=%b rdy=%b exp 00", bus.mem_en, bus.m_ready);
    end
    drive_idle();
  endtask

  task automatic test_ack_at_timeout();
    logic [79:0] rd;
    do_reset();
    rd = {16'($urandom), $urandom, $urandom | 32'h1};
    bus.m_req  = 1'b1;
    bus.m_addr = 64'h900;
    tick();
    repeat (TIMEOUT - 2) tick();
    checks++;
    if (bus.m_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_early got=%b exp=0", bus.m_ready);
    end
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_err   = 1'b1;
    bus.mem_rdata = rd;
    #1;
    checks++;
    if ({bus.m_ready, bus.m_err, bus.m_rdata} !== {2'b11, rd[63:0]}) begin
      errors++;
      $display("FAIL collide_done rdy=%b err=%b rdata=%h exp 1,1,%h",
               bus.m_ready, bus.m_err, bus.m_rdata, rd[63:0]);
    end
    $display("txn collide M addr=900 err=1");
    tick();
    bus.mem_ack = 1'b0;
    bus.m_req   = 1'b0;
    #1;
    checks++;
    if ({bus.m_ready, bus.mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL collide_single rdy=%b en=%b exp 00", bus.m_ready, bus.mem_en);
    end
    drive_idle();
  endtask

  task automatic test_reset_busy();
    do_reset();
    bus.f_req  = 1'b1;
    bus.f_addr = 64'h700;
    tick();
    #2;
    rst_n       = 1'b0;
    bus.f_req   = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 80'hABCD;
    #1;
    checks++;
    if ({bus.f_ready, bus.f_err, bus.f_wait, bus.mem_en, bus.mem_we, bus.mem_addr, bus.f_data} !== '0) begin
      errors++;
      $display("FAIL rstbusy_zero rdy=%b err=%b wait=%b en=%b we=%b addr=%h data=%h exp 0",
               bus.f_ready, bus.f_err, bus.f_wait, bus.mem_en, bus.mem_we, bus.mem_addr, bus.f_data);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.f_ready, bus.mem_en} !== 2'b00) begin
        errors++;
        $display("FAIL rstbusy_no_ready%0d rdy=%b en=%b exp 00", i, bus.f_ready, bus.mem_en);
      end
    end
    bus.mem_ack = 1'b0;
    bus.f_req   = 1'b1;
    bus.f_addr  = 64'h500;
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 64'h500}) begin
      errors++;
      $display("FAIL rstbusy_regrant en=%b addr=%h exp 1,500", bus.mem_en, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 80'h55AA;
    #1;
    checks++;
    if ({bus.f_ready, bus.f_data} !== {1'b1, 80'h55AA}) begin
      errors++;
      $display("FAIL rstbusy_done rdy=%b data=%h exp 1,55aa", bus.f_ready, bus.f_data);
    end
    $display("txn after reset F addr=500");
    tick();
    drive_idle();
  endtask

  // Randomized traffic. The model knows only the arbitration rules: who
  // owns the memory, how long the owner has waited, how many memory grants
  // fetch has sat through.
  task automatic test_random();
    int          owner;      // 0 none, 1 fetch, 2 memory stage
    int          age;
    int          starve;
    bit          slow;
    bit          done;
    logic [63:0] exp_addr;
    logic        exp_we;
    logic [63:0] exp_wd;
    logic        efr, emr, efe, eme;
    logic [79:0] efd;
    logic [63:0] emd;
    logic [79:0] rd;
    logic [6:0]  obs, exp;
    owner  = 0;
    age    = 0;
    starve = 0;
    slow   = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!bus.f_req && $urandom_range(0, 3) == 0) begin
        bus.f_req  = 1'b1;
        bus.f_addr = {$urandom, $urandom};
      end
      if (!bus.m_req && $urandom_range(0, 2) == 0) begin
        bus.m_req   = 1'b1;
        bus.m_we    = 1'($urandom);
        bus.m_addr  = {$urandom, $urandom};
        bus.m_wdata = {$urandom, $urandom};
      end
      if (owner != 0) bus.mem_ack = !slow && ($urandom_range(0, 3) == 0);
      else bus.mem_ack = ($urandom_range(0, 5) == 0);
      bus.mem_err   = ($urandom_range(0, 4) == 0);
      rd            = {16'($urandom), $urandom, $urandom};
      bus.mem_rdata = rd;
      #1;

      done = (owner != 0) && (bus.mem_ack || age == TIMEOUT - 1);
      efr  = done && owner == 1;
      emr  = done && owner == 2;
      efe  = efr && (!bus.mem_ack || bus.mem_err);
      eme  = emr && (!bus.mem_ack || bus.mem_err);
      efd  = (efr && bus.mem_ack) ? rd : 80'd0;
      emd  = (emr && bus.mem_ack) ? rd[63:0] : 64'd0;
      exp  = {efr, emr, efe, eme, bus.f_req && !efr, bus.m_req && !emr, owner != 0};
      obs  = {bus.f_ready, bus.m_ready, bus.f_err, bus.m_err, bus.f_wait, bus.m_wait, bus.mem_en};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rnd_flags cyc=%0d {frdy,mrdy,ferr,merr,fwait,mwait,en} got=%b exp=%b",
                 cyc, obs, exp);
      end
      checks++;
      if ({bus.f_data, bus.m_rdata} !== {efd, emd}) begin
        errors++;
        $display("FAIL rnd_data cyc=%0d fdata=%h mrdata=%h exp %h %h",
                 cyc, bus.f_data, bus.m_rdata, efd, emd);
      end
      if (owner != 0) begin
        checks++;
        if ({bus.mem_addr, bus.mem_we} !== {exp_addr, exp_we} ||
            (owner == 2 && bus.mem_wdata !== exp_wd)) begin
          errors++;
          $display("FAIL rnd_bus cyc=%0d addr=%h we=%b wdata=%h exp %h %b %h",
                   cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata, exp_addr, exp_we, exp_wd);
        end
      end

      if (done) begin
        $display("txn rnd cyc=%0d %s addr=%h err=%b %s", cyc, (owner == 1) ? "F" : "M",
                 exp_addr, efe | eme, bus.mem_ack ? "ack" : "timeout");
        owner = 0;
      end else if (owner != 0) begin
        age++;
      end else if (bus.m_req && (!bus.f_req || starve < STARVE_MAX)) begin
        owner    = 2;
        age      = 0;
        starve   = bus.f_req ? starve + 1 : 0;
        exp_addr = bus.m_addr;
        exp_we   = bus.m_we;
        exp_wd   = bus.m_wdata;
        slow     = ($urandom_range(0, 5) == 0);
      end else if (bus.f_req) begin
        owner    = 1;
        age      = 0;
        starve   = 0;
        exp_addr = bus.f_addr;
        exp_we   = 1'b0;
        slow     = ($urandom_range(0, 5) == 0);
      end

      tick();
      if (efr) bus.f_req = 1'b0;
      if (emr) bus.m_req = 1'b0;
    end
    drive_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle();
    test_reset();
    test_fetch_read();
    test_priority();
    test_starvation();
    test_timeout();
    test_ack_at_timeout();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
